// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

    // Operation codes as presented on the op input.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    // Sequencer states: wait for start, iterate, apply sign and write back.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
) ();
    import mdu_pkg::*;

    logic             start;
    op_e              op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side: issues operations and MTHI/MTLO writes.
    modport master (
        output start, op, rs_val, rt_val, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    // Unit side.
    modport slave (
        input  start, op, rs_val, rt_val, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the unsigned datapath on a shared 2*WIDTH accumulator.
//   multiply: acc = {partial product, remaining multiplier bits}
//   divide:   acc = {partial remainder, dividend bits / quotient bits}
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] diff;
    logic             geq;

    // Multiply: add the multiplicand into the upper half when the current multiplier bit is set.
    assign add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: bring the next dividend bit into the remainder and trial-subtract the divisor.
    // With a zero divisor the subtraction always succeeds and the remainder simply
    // collects the dividend, giving quotient all ones and remainder = dividend.
    assign rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign geq       = rem_shift >= {1'b0, opnd};
    assign diff      = rem_shift[WIDTH-1:0] - opnd;

    // Select the shift-add or restoring-subtract update.
    always_comb begin
        // NOTE: assign a default before any branching so no path leaves acc_next unassigned (no latch).
        acc_next = acc;
        if (is_div) begin
            if (geq) acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            else     acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operands are reduced to magnitudes at start, iterated WIDTH times unsigned,
// then sign-corrected once in the FIX state.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_main_q, neg_main_d;  // product / quotient sign
    logic               neg_rem_q, neg_rem_d;    // remainder sign (dividend's)
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               start_signed, start_div, rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic               is_div_op;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // Magnitudes; the most-negative value maps onto itself, which is its correct unsigned magnitude.
    assign start_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign start_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign rs_neg       = start_signed & bus.rs_val[WIDTH-1];
    assign rt_neg       = start_signed & bus.rt_val[WIDTH-1];
    assign rs_mag       = rs_neg ? -bus.rs_val : bus.rs_val;
    assign rt_mag       = rt_neg ? -bus.rt_val : bus.rt_val;

    assign is_div_op = (op_q == OP_DIV) || (op_q == OP_DIVU);

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_op),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (step_acc)
    );

    assign prod_fix = neg_main_q ? -acc_q : acc_q;
    assign quot_fix = neg_main_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // Next-state and datapath selection for the IDLE -> CALC -> FIX sequence.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // start takes priority; a simultaneous MTHI/MTLO is dropped
                    op_d       = bus.op;
                    acc_d      = {{WIDTH{1'b0}}, (start_div ? rs_mag : rt_mag)};
                    opnd_d     = start_div ? rt_mag : rs_mag;
                    neg_main_d = rs_neg ^ rt_neg;
                    neg_rem_d  = rs_neg;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = S_CALC;
                end else begin
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_op) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                cnt_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All state registers with synchronous reset; a reset mid-operation discards it.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_MULT;
            acc_q      <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a cycle-level reference model built
// from plain 64-bit arithmetic is compared every cycle, and hand-computed
// results pin both the model and the DUT for the directed vectors.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} from the instruction definitions.
    function automatic logic [63:0] golden(input op_e op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, p, q, r;
        logic [63:0] res;
        logic [31:0] qm;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (op)
            OP_MULT: begin
                p   = sa * sb;
                res = p;
            end
            OP_MULTU: res = {32'b0, a} * {32'b0, b};
            OP_DIVU: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
            OP_DIV: begin
                if (b == 0) begin
                    // magnitude quotient is all ones; signs applied as usual
                    qm  = 32'hFFFF_FFFF;
                    res = {a, (a[31] ? -qm : qm)};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Reference model: latency countdown plus architectural HI/LO.
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;
    int          m_left = 0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
            chk_en <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                end
                m_left <= m_left - 1;
            end else if (bus.start) begin
                m_res  <= golden(bus.op, bus.rs_val, bus.rt_val);
                m_busy <= 1'b1;
                m_left <= W + 1;
            end else begin
                if (bus.mthi) m_hi <= bus.wdata;
                if (bus.mtlo) m_lo <= bus.wdata;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 64'(bus.busy), 64'(m_busy));
            check("cyc_done", 64'(bus.done), 64'(m_done));
            check("cyc_hi", 64'(bus.hi), 64'(m_hi));
            check("cyc_lo", 64'(bus.lo), 64'(m_lo));
            check("cyc_done_not_busy", 64'(bus.done & bus.busy), 64'd0);
        end
    end

    // Issue a one-cycle start; called and returns on a falling edge.
    task automatic launch(input op_e op, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done, counting sampled busy cycles on the way.
    task automatic wait_done(output int busy_cycles);
        bit seen;
        seen        = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_cycles++;
            @(negedge clk);
        end
        check("done_seen", 64'(seen), 64'd1);
    endtask

    typedef struct {
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t        vecs[12];
    int          bc;
    logic [31:0] saved_hi;

    initial begin
        vecs[0]  = '{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{OP_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
        vecs[5]  = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0001};
        vecs[6]  = '{OP_MULT,  32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[9]  = '{OP_MULTU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[10] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[11] = '{OP_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};

        bus.start  = 1'b0;
        bus.op     = OP_MULT;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.mthi   = 1'b0;
        bus.mtlo   = 1'b0;
        bus.wdata  = '0;
        reset      = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);

        // Directed vectors: pin the model, then the DUT, then the latency.
        for (int i = 0; i < 12; i++) begin
            check($sformatf("model_v%0d", i), golden(vecs[i].op, vecs[i].a, vecs[i].b),
                  {vecs[i].hi, vecs[i].lo});
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(bc);
            check($sformatf("hi_v%0d", i), 64'(bus.hi), 64'(vecs[i].hi));
            check($sformatf("lo_v%0d", i), 64'(bus.lo), 64'(vecs[i].lo));
            check($sformatf("busy_len_v%0d", i), 64'(bc), 64'd33);
            @(negedge clk);
        end

        // start and mthi while busy are both ignored.
        saved_hi = bus.hi;
        launch(OP_MULTU, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = OP_DIVU;
        bus.rs_val = 32'd9;
        bus.rt_val = 32'd2;
        bus.mthi   = 1'b1;
        bus.wdata  = 32'h0000_00AA;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        check("busy_hold_hi", 64'(bus.hi), 64'(saved_hi));
        wait_done(bc);
        check("busy_ign_hi", 64'(bus.hi), 64'h0);
        check("busy_ign_lo", 64'(bus.lo), 64'hC);
        @(negedge clk);
        check("busy_ign_no_restart", 64'(bus.busy), 64'd0);

        // Reset mid-operation aborts; a following op completes normally.
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(bc);
        check("after_abort_len", 64'(bc), 64'd33);
        check("after_abort_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        check("after_abort_lo", 64'(bus.lo), 64'h0000_0001);
        @(negedge clk);

        // MTHI and MTLO together, then MTHI alone.
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h1234_5678;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mt_both_hi", 64'(bus.hi), 64'h1234_5678);
        check("mt_both_lo", 64'(bus.lo), 64'h1234_5678);
        bus.mthi  = 1'b1;
        bus.wdata = 32'hCAFE_0001;
        @(negedge clk);
        bus.mthi = 1'b0;
        check("mthi_only_hi", 64'(bus.hi), 64'hCAFE_0001);
        check("mthi_only_lo", 64'(bus.lo), 64'h1234_5678);

        // start with mtlo in the same cycle: the write is dropped, the op lands.
        bus.start  = 1'b1;
        bus.op     = OP_MULTU;
        bus.rs_val = 32'd5;
        bus.rt_val = 32'd6;
        bus.mtlo   = 1'b1;
        bus.wdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mtlo  = 1'b0;
        check("start_mtlo_drop", 64'(bus.lo), 64'h1234_5678);
        wait_done(bc);
        check("start_mtlo_hi", 64'(bus.hi), 64'h0);
        check("start_mtlo_lo", 64'(bus.lo), 64'h1E);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
